serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor that reuses a single full-adder cell over `WIDTH` clock cycles, LSB first, to produce a `WIDTH`-bit sum, carry-out and optional signed-overflow flag. It generalises the combinational 1-bit full adder into a multi-bit, multi-cycle arithmetic unit with a start/busy/done handshake. It sits beside the ALU as the area-minimal add/sub path for the gate-level CPU.

---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cy_q;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] cat;

  logic fa_a;
  logic fa_b;
  logic fa_s;
  logic fa_c;
  logic last;
  logic accept;
  logic run;

  assign run    = (state == RUN);
  assign accept = start && !run;
  assign last   = (cnt == CW'(WIDTH - 1));

  assign fa_a = a_q[cnt];
  assign fa_b = b_q[cnt];
  assign fa_s = fa_a ^ fa_b ^ cy_q;
  assign fa_c = (fa_a & fa_b) | (cy_q & (fa_a ^ fa_b));

  // New bit enters at the top; after the last bit cat holds the full result.
  assign cat = {fa_s, sr};

  assign busy = run;
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      cy_q <= 1'b0;
      sr   <= '0;
    end else if (accept) begin
      cnt  <= '0;
      a_q  <= a;
      b_q  <= b ^ {WIDTH{sub}};
      cy_q <= c_in ^ sub;
    end else if (run) begin
      cy_q <= fa_c;
      sr   <= cat[WIDTH-1:1];
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else if (run && last) begin
      sum   <= cat;
      c_out <= fa_c;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // cy_q at the last step is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= cy_q ^ fa_c;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed, random,
// handshake and mid-run reset scenarios against an integer reference model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out),
    .ovf  (ovf)
  );

  function automatic void model(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       s,
    input  logic       ci,
    output logic [7:0] r,
    output logic       co,
    output logic       ov
  );
    int tu;
    int ts;
    if (!s) begin
      tu = int'(x) + int'(y) + int'(ci);
      ts = int'($signed(x)) + int'($signed(y)) + int'(ci);
      co = (tu > 255);
    end else begin
      tu = int'(x) - int'(y) - int'(ci);
      ts = int'($signed(x)) - int'($signed(y)) - int'(ci);
      co = (tu >= 0);
    end
    r  = tu[7:0];
    ov = OVF_ON && (ts > 127 || ts < -128);
  endfunction

  task automatic issue(input logic [7:0] x, input logic [7:0] y,
                       input logic s, input logic ci);
    @(negedge clk);
    a = x; b = y; sub = s; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = number of negedges since start was dropped (1-based); -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #12;
    checks++;
    if ({busy, done, sum, c_out, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b ovf=%b want all 0",
               busy, done, sum, c_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [7:0] va [4]  = '{8'h5A, 8'hFF, 8'h10, 8'h80};
    logic [7:0] vb [4]  = '{8'h3C, 8'h01, 8'h20, 8'h01};
    logic       vs [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       vc [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] es [4]  = '{8'h96, 8'h01, 8'hF0, 8'h7F};
    logic       eco [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eov [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vs[i], vc[i]);
      wait_done(lat);
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d want 9", i, lat);
      end
      checks++;
      if ({sum, c_out, ovf} !== {es[i], eco[i], eov[i] & OVF_ON}) begin
        errors++;
        $display("FAIL dir%0d_result: got sum=%h c_out=%b ovf=%b want sum=%h c_out=%b ovf=%b",
                 i, sum, c_out, ovf, es[i], eco[i], eov[i] & OVF_ON);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy_in_done: got %b want 0", i, busy);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] x, y, r;
    logic s, ci, co, ov;
    int lat;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      s = 1'($urandom); ci = 1'($urandom);
      model(x, y, s, ci, r, co, ov);
      issue(x, y, s, ci);
      wait_done(lat);
      checks++;
      if (lat !== 9 || {sum, c_out, ovf} !== {r, co, ov}) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h sub=%b cin=%b got lat=%0d sum=%h c=%b v=%b want lat=9 sum=%h c=%b v=%b",
                 i, x, y, s, ci, lat, sum, c_out, ovf, r, co, ov);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [7:0] r;
    logic co, ov;
    int lat;
    model(8'h33, 8'h44, 1'b0, 1'b1, r, co, ov);
    issue(8'h33, 8'h44, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a = 8'hC7; b = 8'h9E; sub = 1'b1; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL ignore_latency: got %0d want 6", lat);
    end
    checks++;
    if ({sum, c_out, ovf} !== {r, co, ov}) begin
      errors++;
      $display("FAIL ignore_result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
               sum, c_out, ovf, r, co, ov);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_no_rerun: got busy=%b done=%b want 00", busy, done);
    end
  endtask

  task automatic test_stable;
    logic [7:0] r1, r2;
    logic c1, v1, c2, v2;
    int lat;
    int bad;
    model(8'hA5, 8'h0F, 1'b1, 1'b1, r1, c1, v1);
    model(8'h7E, 8'h6B, 1'b0, 1'b0, r2, c2, v2);
    issue(8'hA5, 8'h0F, 1'b1, 1'b1);
    wait_done(lat);
    issue(8'h7E, 8'h6B, 1'b0, 1'b0);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      if ({sum, c_out, ovf, busy, done} !== {r1, c1, v1, 1'b1, 1'b0}) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stable_during_run: got %0d unstable cycles want 0", bad);
    end
    checks++;
    if (done !== 1'b1 || {sum, c_out, ovf} !== {r2, c2, v2}) begin
      errors++;
      $display("FAIL stable_final: got done=%b sum=%h c=%b v=%b want done=1 sum=%h c=%b v=%b",
               done, sum, c_out, ovf, r2, c2, v2);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r1, r2;
    logic c1, v1, c2, v2;
    int lat;
    model(8'h12, 8'hF3, 1'b0, 1'b0, r1, c1, v1);
    model(8'h40, 8'hC0, 1'b1, 1'b1, r2, c2, v2);
    issue(8'h12, 8'hF3, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 9 || {sum, c_out, ovf} !== {r1, c1, v1}) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d sum=%h c=%b v=%b want lat=9 sum=%h c=%b v=%b",
               lat, sum, c_out, ovf, r1, c1, v1);
    end
    a = 8'h40; b = 8'hC0; sub = 1'b1; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b want 10", busy, done);
    end
    wait_done(lat);
    checks++;
    if (lat !== 9 || {sum, c_out, ovf} !== {r2, c2, v2}) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d sum=%h c=%b v=%b want lat=9 sum=%h c=%b v=%b",
               lat, sum, c_out, ovf, r2, c2, v2);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] r;
    logic co, ov;
    int lat;
    int seen;
    issue(8'hFF, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, c_out, ovf} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b done=%b sum=%h c=%b v=%b want all 0",
               busy, done, sum, c_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d active cycles want 0", seen);
    end
    model(8'h5A, 8'h3C, 1'b0, 1'b0, r, co, ov);
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 9 || {sum, c_out, ovf} !== {r, co, ov}) begin
      errors++;
      $display("FAIL midrst_fresh: got lat=%0d sum=%h c=%b v=%b want lat=9 sum=%h c=%b v=%b",
               lat, sum, c_out, ovf, r, co, ov);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_stable();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
